// File: rtl/aes_top.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// Optional macro AES_ROUND_OUT_EN adds the round_idx output port.
module aes_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] key,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
`ifdef AES_ROUND_OUT_EN
  ,
  output logic [3:0]   round_idx
`endif
);

  typedef enum logic {IDLE, RUN} st_t;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24]; a1 = col[23:16]; a2 = col[15:8]; a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  st_t          st_reg, st_next;
  logic [3:0]   round_reg;
  logic [127:0] state_reg, rkey_reg;

  logic [7:0]   sb [16];
  logic [7:0]   ks [4];
  logic [31:0]  rot_w3, temp_w, nw0, nw1, nw2, nw3;
  logic [127:0] sr_vec, mc_vec, nrk, rnd_res;
  logic         last_round;

  assign last_round = (round_reg == 4'd10);
  assign rot_w3     = {rkey_reg[23:0], rkey_reg[31:24]};

  genvar gi;
  for (gi = 0; gi < 16; gi++) begin : g_state_sbox
    assign sb[gi] = sbox(state_reg[127-8*gi -: 8]);
  end
  for (gi = 0; gi < 4; gi++) begin : g_key_sbox
    assign ks[gi] = sbox(rot_w3[31-8*gi -: 8]);
  end

  assign temp_w = {ks[0] ^ rcon(round_reg), ks[1], ks[2], ks[3]};
  assign nw0    = rkey_reg[127:96] ^ temp_w;
  assign nw1    = rkey_reg[95:64] ^ nw0;
  assign nw2    = rkey_reg[63:32] ^ nw1;
  assign nw3    = rkey_reg[31:0] ^ nw2;
  assign nrk    = {nw0, nw1, nw2, nw3};

  // ShiftRows: row r of column c comes from column (c + r) mod 4
  always_comb begin
    sr_vec = '0;
    mc_vec = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_vec[127-8*(4*c+r) -: 8] = sb[4*((c+r)%4)+r];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc_vec[127-32*c -: 32] = mix_col(sr_vec[127-32*c -: 32]);
    end
  end

  assign rnd_res = (last_round ? sr_vec : mc_vec) ^ nrk;

  always_ff @(posedge clk) begin
    if (rst) st_reg <= IDLE;
    else     st_reg <= st_next;
  end

  always_comb begin
    st_next = st_reg;
    case (st_reg)
      IDLE:    if (start) st_next = RUN;
      RUN:     if (last_round) st_next = IDLE;
      default: st_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (st_reg == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= '0;
      rkey_reg  <= '0;
      round_reg <= '0;
      out       <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (st_reg == IDLE) begin
        if (start) begin
          state_reg <= in ^ key;
          rkey_reg  <= key;
          round_reg <= 4'd1;
        end
      end else begin
        rkey_reg <= nrk;
        if (last_round) begin
          out       <= rnd_res;
          done      <= 1'b1;
          round_reg <= 4'd0;
        end else begin
          state_reg <= rnd_res;
          round_reg <= round_reg + 4'd1;
        end
      end
    end
  end

`ifdef AES_ROUND_OUT_EN
  assign round_idx = round_reg;
`endif

endmodule

// File: tb/tb_aes_top.sv
// Directed bench for aes_top using FIPS-197 vectors; outputs are sampled on the falling edge.
module tb_aes_top;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] din = '0;
  logic [127:0] dkey = '0;
  logic [127:0] dout;
  logic         busy, done;
`ifdef AES_ROUND_OUT_EN
  logic [3:0]   round_idx;
`endif

  aes_top dut (
    .clk(clk), .rst(rst), .start(start), .in(din), .key(dkey),
    .out(dout), .busy(busy), .done(done)
`ifdef AES_ROUND_OUT_EN
    , .round_idx(round_idx)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] B_IN  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_OUT = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C_IN  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Z_OUT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  int passed = 0;
  int total = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called at a falling edge; returns at the falling edge right after the accept edge.
  task automatic go(input logic [127:0] i, input logic [127:0] k);
    start = 1'b1; din = i; dkey = k;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc, output int busy_cyc);
    cyc = 0; busy_cyc = 0;
    while (!done && cyc < limit) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc, bcyc, d0;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out", dout, '0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // App. B vector with latency and pulse width
    d0 = done_cnt;
    go(B_IN, B_KEY);
    chk("b_busy_after_accept", busy, 1'b1);
    wait_done(20, cyc, bcyc);
    chk("b_done_seen", done, 1'b1);
    chk("b_latency", cyc, 10);
    chk("b_out", dout, B_OUT);
    chk("b_busy_in_done_cycle", busy, 1'b0);
    @(negedge clk);
    chk("b_done_one_cycle", done, 1'b0);
    chk("b_out_held", dout, B_OUT);
    $display("txn appB: out=%h latency=%0d", dout, cyc);

    // App. C.1 vector
    go(C_IN, C_KEY);
    wait_done(20, cyc, bcyc);
    chk("c1_out", dout, C_OUT);
    $display("txn appC1: out=%h latency=%0d", dout, cyc);
    @(negedge clk);

    // All-zero block and key
    d0 = done_cnt;
    go('0, '0);
    wait_done(20, cyc, bcyc);
    chk("zero_out", dout, Z_OUT);
    chk("zero_busy_cycles", bcyc, 10);
    repeat (3) @(negedge clk);
    chk("zero_done_pulses", done_cnt - d0, 1);
    $display("txn zero: out=%h busy_cycles=%0d", Z_OUT, bcyc);

    // Start while busy must be ignored, including later in/key changes
    d0 = done_cnt;
    go(B_IN, B_KEY);
    din = 128'hdeadbeef; dkey = 128'h12345678;
    repeat (2) @(negedge clk);
    go(C_IN, C_KEY);
    din = '1; dkey = '1;
    wait_done(20, cyc, bcyc);
    chk("busy_start_done_seen", done, 1'b1);
    chk("busy_start_out", dout, B_OUT);
    repeat (15) @(negedge clk);
    chk("busy_start_one_done", done_cnt - d0, 1);
    chk("busy_start_idle", busy, 1'b0);
    $display("txn start_while_busy: out=%h dones=%0d", dout, done_cnt - d0);

    // Reset during round 5 aborts without a done
    d0 = done_cnt;
    go(C_IN, C_KEY);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out", dout, '0);
    chk("abort_busy", busy, 1'b0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    go(C_IN, C_KEY);
    wait_done(20, cyc, bcyc);
    chk("abort_rerun_out", dout, C_OUT);
    $display("txn abort_then_c1: out=%h", dout);
    @(negedge clk);

    // Back-to-back: new start during the done cycle
    go(B_IN, B_KEY);
    wait_done(20, cyc, bcyc);
    chk("b2b_first_out", dout, B_OUT);
    go(C_IN, C_KEY);
    wait_done(20, cyc, bcyc);
    chk("b2b_done_spacing", cyc + 1, 11);
    chk("b2b_second_out", dout, C_OUT);
    $display("txn back_to_back: out=%h spacing=%0d", dout, cyc + 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/aes_top.md
Name: aes_top

Overview:
- Iterative AES-128 encryption core (FIPS-197): one 128-bit plaintext block and one 128-bit cipher key in, one 128-bit ciphertext block out.
- Computes one round per clock.
- Expands round keys on the fly, so no key-schedule RAM is needed.
- Sits as a leaf crypto engine under a bus/stream wrapper that supplies blocks with a start pulse and collects the result on done.

Parameters:
- None. Key size is fixed at 128 bits and round count at 10.

Ports:
- clk    in   1    rising-edge clock
- rst    in   1    synchronous, active-high reset
- start  in   1    request to encrypt; sampled only while busy=0
- in     in   128  plaintext block; bits [127:120] = byte 0
- key    in   128  cipher key; bits [127:120] = byte 0
- out    out  128  ciphertext, registered; held until the next completion
- busy   out  1    high while a block is in flight
- done   out  1    one-cycle pulse when out is updated

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. On rst: out=0, busy=0, done=0, round counter=0, internal state and round-key registers=0. rst wins over start.
- Byte mapping: byte i of a 128-bit word = bits [127-8i -: 8]. State is column-major: byte i sits at row i%4, column i/4. This matches FIPS-197 vectors written as plain hex strings.
- Start (IDLE -> RUN): at an edge where start=1 and busy=0:
  - state <= in ^ key (initial AddRoundKey)
  - round key <= key
  - round <= 1, busy <= 1
  - in and key are captured at this edge only; later changes have no effect.
- RUN, rounds 1..9: each edge does:
  - compute the next round key from the previous one: RotWord, SubWord, XOR Rcon[round] into word 0; Rcon = 01,02,04,08,10,20,40,80,1b,36
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ new round key
  - round increments.
- Round 10: same as rounds 1..9 but MixColumns is omitted. The result goes directly into out. At the same edge done <= 1 and busy <= 0, with round returning to 0.
- Latency: start accepted at edge T, so out is valid and done is high in the cycle after edge T+10. Throughput is one block per 11 cycles; start may be asserted during the done cycle.
- done is high for exactly one cycle per block. out keeps its value until the next completion or rst.
- start while busy=1 is ignored, with no queuing.
- rst mid-operation aborts: out returns to 0 and no done is produced.
- S-box: a 256-entry constant function, instantiated 16x for the state and 4x for the key schedule.
- MixColumns uses xtime (shift left; XOR 0x1b on carry). All arithmetic is in GF(2^8).
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro: AES_ROUND_OUT_EN.
- Defined: adds output port round_idx [3:0]. Value is 0 when idle and 1..10 equal to the round being computed in that cycle (1 in the cycle after start acceptance, up to 10). It is reset to 0.
- Not defined: the port is absent. Functionality and timing are otherwise identical.

Test Plan:
- FIPS-197 App. B:
  - stimulus: in=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, start pulse
  - response: done exactly 10 cycles after the accept edge, out=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1:
  - stimulus: in=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f
  - response: out=69c4e0d86a7b0430d8cdb78070b4c55a.
- All-zero in and key:
  - response: out=66e94bd4ef8a2c3b884cfa59ca342b2e.
  - check: busy is high for exactly 10 cycles and done pulses once.
- Start while busy, with changing in/key:
  - stimulus: start the App. B vector, then pulse start with new in/key 3 cycles later
  - response: second request ignored; out=3925841d...0b32; only one done.
- Reset mid-operation:
  - stimulus: assert rst at round 5
  - response: out=0, busy=0, no done.
  - follow-up: a fresh App. C.1 run then completes correctly.
- Back-to-back:
  - stimulus: start asserted during the done cycle of the App. B run with the C.1 vector
  - response: second done 11 cycles after the first, with the correct C.1 ciphertext.
